bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: max cycles m_req is held without m_ack before abort; legal range 1..65535.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 i_req  input  1  fetch port request; held with i_addr stable until i_ack.
REQ-005 i_addr  input  32  fetch word address.
REQ-006 i_ack  output  1  one-cycle completion pulse to fetch port.
REQ-007 i_err  output  1  one-cycle timeout pulse, coincident with i_ack.
REQ-008 i_rdata  output  32  fetched word, valid while i_ack=1.
REQ-009 d_req  input  1  data port request; held with d_rw/d_addr/d_wdata stable until d_ack.
REQ-010 d_rw  input  1  1=write, 0=read.
REQ-011 d_addr  input  32  data word address.
REQ-012 d_wdata  input  32  write data.
REQ-013 d_ack  output  1  one-cycle completion pulse to data port.
REQ-014 d_err  output  1  one-cycle timeout pulse, coincident with d_ack.
REQ-015 d_rdata  output  32  read data, valid while d_ack=1 and the access was a read.
REQ-016 m_req  output  1  registered memory request, held until m_ack or timeout.
REQ-017 m_rw  output  1  1=write; always 0 for fetch.
REQ-018 m_addr  output  32  latched address; 0 when m_req=0.
REQ-019 m_wdata  output  32  latched write data; 0 unless m_req=1 and m_rw=1.
REQ-020 m_ack  input  1  memory completion, sampled only while m_req=1.
REQ-021 m_rdata  input  32  memory read data, valid with m_ack.
REQ-022 busy  output  1  1 when state is not IDLE.

Function
REQ-023 States IDLE, BUSY_I, BUSY_D; one outstanding memory access at a time.
REQ-024 IDLE: eligible requester = req high and own ack not currently asserted (masks the req still held in the ack cycle).
REQ-025 IDLE, one eligible: grant it; latch addr/rw/wdata (fetch: rw=0, wdata=0); next state BUSY_I/BUSY_D; m_req=1 from next cycle.
REQ-026 IDLE, both eligible: grant port opposite to prio bit; prio := granted port; prio resets to I, so first tie goes to D.
REQ-027 Single-requester grant also updates prio.
REQ-028 BUSY_x, m_ack=1: capture m_rdata into x_rdata (0 for writes), pulse x_ack next cycle, m_req=0 next cycle, return to IDLE.
REQ-029 Latency: req high in IDLE cycle 0 -> m_req cycle 1 -> m_ack in cycle k>=1 -> x_ack cycle k+1; minimum 2 cycles.
REQ-030 Throughput: at least one idle cycle on m_req between consecutive accesses.
REQ-031 16-bit wait counter cleared on grant, incremented each BUSY cycle with m_ack=0; reaching TIMEOUT -> drop m_req, pulse x_ack and x_err together, x_rdata=0, return to IDLE.
REQ-032 m_ack in the same cycle the counter reaches TIMEOUT: completion wins, no err.
REQ-033 m_ack while m_req=0 ignored; x_rdata holds last value between acks.
REQ-034 Requester dropping req while BUSY for it: access still completes and acks; no cancellation.
REQ-035 i_ack and d_ack never both 1 in the same cycle.

Reset
REQ-036 reset=1 at an edge: state IDLE, prio=I, counter 0; m_req, m_rw, m_addr, m_wdata, i_ack, d_ack, i_err, d_err, i_rdata, d_rdata, busy all 0.
REQ-037 Reset mid-access: access abandoned, no ack/err pulse, m_req 0 next cycle; reset dominates m_ack.

Verification
REQ-038 Fetch only: i_req=1, i_addr=0x1000, m_ack=1 one cycle after m_req, m_rdata=0xDEADBEEF -> m_addr=0x1000, m_rw=0, i_ack cycle 3, i_rdata=0xDEADBEEF, i_err=0.
REQ-039 Tie after reset: i_req=d_req=1 same cycle, d_rw=1, d_addr=0x20, d_wdata=0x5A5A5A5A -> D served first (m_rw=1, m_wdata=0x5A5A5A5A), then I; next tie goes to D again.
REQ-040 Ack-cycle masking: requester holds req through its ack cycle, other idle -> exactly one m_req pulse, one ack.
REQ-041 Timeout: TIMEOUT=4, d_req read, m_ack never -> m_req high 4 cycles, then d_ack=d_err=1, d_rdata=0, busy=0.
REQ-042 Reset while BUSY_I with m_ack=1 same cycle -> no i_ack, all outputs 0 next cycle.
REQ-043 Stress: random req/m_ack delays 0..10 for 10k cycles -> each accepted request acked exactly once, no dual acks, no starvation beyond 1 competing access.

Source files
------------

// File: rtl/bus_arbiter_if.sv
// Single-outstanding memory bus between the arbiter (master) and the memory (slave).
// m_req is held until m_ack or abort; m_ack/m_rdata are only meaningful while m_req=1.
interface bus_arbiter_if;
  logic        m_req;
  logic        m_rw;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_ack;
  logic [31:0] m_rdata;

  modport master (
    output m_req, m_rw, m_addr, m_wdata,
    input  m_ack, m_rdata
  );

  modport slave (
    input  m_req, m_rw, m_addr, m_wdata,
    output m_ack, m_rdata
  );
endinterface

// File: rtl/bus_arbiter.sv
// Fetch/data arbiter onto one memory bus; req->m_req 1 cycle, m_ack->x_ack 1 cycle (min 2).
// Requesters are backpressured by holding req until their ack; memory stalls abort after TIMEOUT cycles.
module bus_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic        i_err,
  output logic [31:0] i_rdata,

  input  logic        d_req,
  input  logic        d_rw,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic        d_err,
  output logic [31:0] d_rdata,

  bus_arbiter_if.master mem,

  output logic        busy
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic        prio_d;
  logic [15:0] wait_cnt;

  logic i_elig;
  logic d_elig;
  logic grant_d;
  logic timed_out;

  // A requester still holding req during its own ack cycle is not a new request.
  assign i_elig    = i_req && !i_ack;
  assign d_elig    = d_req && !d_ack;
  assign grant_d   = d_elig && (!i_elig || !prio_d);
  assign timed_out = (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      prio_d      <= 1'b0;
      wait_cnt    <= '0;
      busy        <= 1'b0;
      mem.m_req   <= 1'b0;
      mem.m_rw    <= 1'b0;
      mem.m_addr  <= '0;
      mem.m_wdata <= '0;
      i_ack       <= 1'b0;
      i_err       <= 1'b0;
      i_rdata     <= '0;
      d_ack       <= 1'b0;
      d_err       <= 1'b0;
      d_rdata     <= '0;
    end else begin
      i_ack <= 1'b0;
      i_err <= 1'b0;
      d_ack <= 1'b0;
      d_err <= 1'b0;
      case (state)
        IDLE: begin
          if (i_elig || d_elig) begin
            wait_cnt  <= '0;
            busy      <= 1'b1;
            mem.m_req <= 1'b1;
            prio_d    <= grant_d;
            if (grant_d) begin
              state       <= BUSY_D;
              mem.m_rw    <= d_rw;
              mem.m_addr  <= d_addr;
              mem.m_wdata <= d_rw ? d_wdata : '0;
            end else begin
              state       <= BUSY_I;
              mem.m_rw    <= 1'b0;
              mem.m_addr  <= i_addr;
              mem.m_wdata <= '0;
            end
          end
        end
        BUSY_I, BUSY_D: begin
          // Completion takes priority over a timeout reached in the same cycle.
          if (mem.m_ack || timed_out) begin
            state       <= IDLE;
            busy        <= 1'b0;
            mem.m_req   <= 1'b0;
            mem.m_rw    <= 1'b0;
            mem.m_addr  <= '0;
            mem.m_wdata <= '0;
            if (state == BUSY_I) begin
              i_ack   <= 1'b1;
              i_err   <= !mem.m_ack;
              i_rdata <= mem.m_ack ? mem.m_rdata : '0;
            end else begin
              d_ack   <= 1'b1;
              d_err   <= !mem.m_ack;
              d_rdata <= (mem.m_ack && !mem.m_rw) ? mem.m_rdata : '0;
            end
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed vector table, multi-cycle corner sequences, randomized run vs reference model.
module tb_bus_arbiter;
  localparam int TO = 4;
  localparam int NV = 15;
  localparam int STRESS = 10000;

  typedef struct packed {
    logic        m_req;
    logic        m_rw;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        i_ack;
    logic        i_err;
    logic [31:0] i_rdata;
    logic        d_ack;
    logic        d_err;
    logic [31:0] d_rdata;
    logic        busy;
  } out_t;

  typedef struct packed {
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic        d_rw;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        m_ack;
    logic [31:0] m_rdata;
  } in_t;

  typedef struct packed {
    in_t  stim;
    out_t want;
  } vec_t;

  localparam int OW = $bits(out_t);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        i_req, i_ack, i_err;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_rw, d_ack, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        busy;

  bus_arbiter_if mem();

  bus_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_err(i_err), .i_rdata(i_rdata),
    .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
    .mem(mem), .busy(busy)
  );

  int tests = 0;
  int fails = 0;

  vec_t vecs [NV];
  out_t got, exp_o, nxt;
  int   cnt;

  // Reference model: the one access in flight, described as a transaction record.
  bit          cur_act, cur_d, cur_rw, last_d, ie, de, pd, ok, gen;
  int          cur_age, grants, acks, dual;
  // Stimulus agents.
  bit          ri_req, ri_drop, rd_req, rd_drop, rd_rw, i_wait, d_wait;
  logic [31:0] ri_addr, rd_addr, rd_wdata;
  int          mem_age, mem_dly, byp_i, byp_d;

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  function automatic out_t dut_out();
    out_t o;
    o.m_req = mem.m_req;   o.m_rw = mem.m_rw;
    o.m_addr = mem.m_addr; o.m_wdata = mem.m_wdata;
    o.i_ack = i_ack; o.i_err = i_err; o.i_rdata = i_rdata;
    o.d_ack = d_ack; o.d_err = d_err; o.d_rdata = d_rdata;
    o.busy = busy;
    return o;
  endfunction

  function automatic in_t mk_in(input logic ir, input logic [31:0] ia, input logic dr, input logic drw,
                                input logic [31:0] da, input logic [31:0] dw,
                                input logic ma, input logic [31:0] md);
    in_t s;
    s = '{ir, ia, dr, drw, da, dw, ma, md};
    return s;
  endfunction

  function automatic out_t mk_out(input logic mr, input logic mrw, input logic [31:0] ma, input logic [31:0] mw,
                                  input logic ia, input logic ierr, input logic [31:0] ird,
                                  input logic da, input logic derr, input logic [31:0] drd, input logic b);
    out_t o;
    o = '{mr, mrw, ma, mw, ia, ierr, ird, da, derr, drd, b};
    return o;
  endfunction

  task automatic apply(input in_t s);
    i_req = s.i_req;  i_addr = s.i_addr;
    d_req = s.d_req;  d_rw = s.d_rw; d_addr = s.d_addr; d_wdata = s.d_wdata;
    mem.m_ack = s.m_ack; mem.m_rdata = s.m_rdata;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Tie after reset goes to D (write), then I; a later tie goes to D again; fetch with ack one cycle after m_req.
    vecs[0]  = '{mk_in(1, 32'h40, 1, 1, 32'h20, 32'h5A5A5A5A, 0, 0),
                 mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[1]  = '{mk_in(1, 32'h40, 1, 1, 32'h20, 32'h5A5A5A5A, 1, 32'h11111111),
                 mk_out(1, 1, 32'h20, 32'h5A5A5A5A, 0, 0, 0, 0, 0, 0, 1)};
    vecs[2]  = '{mk_in(1, 32'h40, 1, 1, 32'h20, 32'h5A5A5A5A, 0, 0),
                 mk_out(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0)};
    vecs[3]  = '{mk_in(1, 32'h40, 0, 0, 0, 0, 0, 0),
                 mk_out(1, 0, 32'h40, 0, 0, 0, 0, 0, 0, 0, 1)};
    vecs[4]  = '{mk_in(1, 32'h40, 0, 0, 0, 0, 1, 32'hCAFEF00D),
                 mk_out(1, 0, 32'h40, 0, 0, 0, 0, 0, 0, 0, 1)};
    vecs[5]  = '{mk_in(0, 0, 0, 0, 0, 0, 0, 0),
                 mk_out(0, 0, 0, 0, 1, 0, 32'hCAFEF00D, 0, 0, 0, 0)};
    vecs[6]  = '{mk_in(1, 32'h1000, 1, 0, 32'h24, 0, 0, 0),
                 mk_out(0, 0, 0, 0, 0, 0, 32'hCAFEF00D, 0, 0, 0, 0)};
    vecs[7]  = '{mk_in(1, 32'h1000, 1, 0, 32'h24, 0, 0, 0),
                 mk_out(1, 0, 32'h24, 0, 0, 0, 32'hCAFEF00D, 0, 0, 0, 1)};
    vecs[8]  = '{mk_in(1, 32'h1000, 1, 0, 32'h24, 0, 1, 32'h12345678),
                 mk_out(1, 0, 32'h24, 0, 0, 0, 32'hCAFEF00D, 0, 0, 0, 1)};
    vecs[9]  = '{mk_in(1, 32'h1000, 1, 0, 32'h24, 0, 0, 0),
                 mk_out(0, 0, 0, 0, 0, 0, 32'hCAFEF00D, 1, 0, 32'h12345678, 0)};
    vecs[10] = '{mk_in(1, 32'h1000, 0, 0, 0, 0, 0, 0),
                 mk_out(1, 0, 32'h1000, 0, 0, 0, 32'hCAFEF00D, 0, 0, 32'h12345678, 1)};
    vecs[11] = '{mk_in(1, 32'h1000, 0, 0, 0, 0, 1, 32'hDEADBEEF),
                 mk_out(1, 0, 32'h1000, 0, 0, 0, 32'hCAFEF00D, 0, 0, 32'h12345678, 1)};
    vecs[12] = '{mk_in(1, 32'h1000, 0, 0, 0, 0, 0, 0),
                 mk_out(0, 0, 0, 0, 1, 0, 32'hDEADBEEF, 0, 0, 32'h12345678, 0)};
    vecs[13] = '{mk_in(0, 0, 0, 0, 0, 0, 1, 32'hBAD0BAD0),
                 mk_out(0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0, 32'h12345678, 0)};
    vecs[14] = '{mk_in(0, 0, 0, 0, 0, 0, 0, 0),
                 mk_out(0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0, 32'h12345678, 0)};

    reset = 1'b1;
    apply('0);
    step();
    step();
    reset = 1'b0;

    for (int n = 0; n < NV; n++) begin
      apply(vecs[n].stim);
      check($sformatf("vec%0d", n), dut_out(), vecs[n].want);
      step();
    end

    // Read that memory never answers: aborted after TIMEOUT cycles of m_req.
    apply(mk_in(0, 0, 1, 0, 32'h80, 0, 0, 0));
    step();
    cnt = 0;
    for (int n = 0; n < 20 && mem.m_req; n++) begin
      cnt++;
      step();
    end
    check("timeout_mreq_cycles", OW'(cnt), OW'(TO));
    check("timeout_ack_err_busy", OW'({d_ack, d_err, busy, mem.m_req}), OW'(4'b1100));
    check("timeout_rdata", OW'(d_rdata), '0);
    apply('0);
    step();
    check("timeout_one_pulse", OW'({d_ack, d_err}), '0);

    // m_ack arriving in the cycle the wait counter expires: completion, no error.
    apply(mk_in(0, 0, 1, 0, 32'h84, 0, 0, 0));
    step();
    step();
    step();
    step();
    mem.m_ack = 1'b1;
    mem.m_rdata = 32'h0BADF00D;
    check("edge_mreq_still_high", OW'(mem.m_req), OW'(1'b1));
    step();
    apply('0);
    check("edge_ack_no_err", OW'({d_ack, d_err}), OW'(2'b10));
    check("edge_rdata", OW'(d_rdata), OW'(32'h0BADF00D));

    // Reset while BUSY_I with m_ack in the same cycle: no ack, everything cleared.
    apply(mk_in(1, 32'h2000, 0, 0, 0, 0, 0, 0));
    step();
    check("rst_busy_before", OW'({mem.m_req, busy}), OW'(2'b11));
    mem.m_ack = 1'b1;
    mem.m_rdata = 32'h77777777;
    reset = 1'b1;
    step();
    reset = 1'b0;
    apply('0);
    check("rst_outputs", dut_out(), '0);
    step();
    check("rst_no_late_ack", dut_out(), '0);

    // Randomized run against the transaction-level model.
    exp_o = '0;
    cur_act = 0; last_d = 0; cur_age = 0;
    grants = 0; acks = 0; dual = 0;
    ri_req = 0; ri_drop = 0; rd_req = 0; rd_drop = 0; i_wait = 0; d_wait = 0;
    ri_addr = 0; rd_addr = 0; rd_wdata = 0; rd_rw = 0;
    mem_age = 0; mem_dly = 0; byp_i = 0; byp_d = 0;
    for (int cyc = 0; cyc < STRESS + 40 && fails < 50; cyc++) begin
      gen = (cyc < STRESS);
      got = dut_out();
      check("stress_outputs", got, exp_o);
      if (got.i_ack && got.d_ack) dual++;
      if (got.i_ack || got.d_ack) acks++;
      if (got.d_ack && i_wait) byp_i++;
      if (got.i_ack && d_wait) byp_d++;
      if (got.i_ack) begin
        check("starve_i", OW'(byp_i > 1), '0);
        byp_i = 0; i_wait = 0;
      end
      if (got.d_ack) begin
        check("starve_d", OW'(byp_d > 1), '0);
        byp_d = 0; d_wait = 0;
      end

      if (ri_drop) begin ri_req = 0; ri_drop = 0; end
      if (exp_o.i_ack) begin
        if ($urandom_range(0, 1) == 1) ri_drop = 1;
        else ri_req = 0;
      end
      if (!ri_req && !ri_drop && gen && $urandom_range(0, 2) == 0) begin
        ri_req = 1; ri_addr = $urandom; i_wait = 1;
      end
      if (rd_drop) begin rd_req = 0; rd_drop = 0; end
      if (exp_o.d_ack) begin
        if ($urandom_range(0, 1) == 1) rd_drop = 1;
        else rd_req = 0;
      end
      if (!rd_req && !rd_drop && gen && $urandom_range(0, 2) == 0) begin
        rd_req = 1; rd_addr = $urandom; rd_wdata = $urandom; rd_rw = 1'($urandom_range(0, 1)); d_wait = 1;
      end

      if (exp_o.m_req) begin
        if (mem_age == 0) mem_dly = $urandom_range(0, 10);
        mem.m_ack = (mem_age == mem_dly);
        mem_age++;
      end else begin
        mem_age = 0;
        mem.m_ack = ($urandom_range(0, 7) == 0);
      end
      mem.m_rdata = $urandom;
      i_req = ri_req; i_addr = ri_addr;
      d_req = rd_req; d_rw = rd_rw; d_addr = rd_addr; d_wdata = rd_wdata;

      nxt = exp_o;
      nxt.i_ack = 0; nxt.i_err = 0; nxt.d_ack = 0; nxt.d_err = 0;
      if (cur_act) begin
        cur_age++;
        if (mem.m_ack || cur_age == TO) begin
          ok = mem.m_ack;
          cur_act = 0;
          nxt.m_req = 0; nxt.m_rw = 0; nxt.m_addr = 0; nxt.m_wdata = 0; nxt.busy = 0;
          if (cur_d) begin
            nxt.d_ack = 1; nxt.d_err = !ok;
            nxt.d_rdata = (ok && !cur_rw) ? mem.m_rdata : 32'h0;
          end else begin
            nxt.i_ack = 1; nxt.i_err = !ok;
            nxt.i_rdata = ok ? mem.m_rdata : 32'h0;
          end
        end
      end else begin
        ie = i_req && !exp_o.i_ack;
        de = d_req && !exp_o.d_ack;
        if (ie || de) begin
          pd = (ie && de) ? !last_d : de;
          last_d = pd;
          cur_act = 1; cur_d = pd; cur_age = 0; cur_rw = pd ? d_rw : 1'b0;
          grants++;
          nxt.m_req = 1; nxt.m_rw = cur_rw; nxt.busy = 1;
          nxt.m_addr = pd ? d_addr : i_addr;
          nxt.m_wdata = (pd && d_rw) ? d_wdata : 32'h0;
        end
      end
      exp_o = nxt;
      step();
    end
    check("stress_acks_vs_grants", OW'(acks), OW'(grants));
    check("stress_no_dual_ack", OW'(dual), '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
